bless_inject_ctrl: RTL and testbench



---
 rtl/bless_inject_ctrl.sv | 118 +++++++++++
 tb/tb_bless_inject_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/bless_inject_ctrl.sv
// BLESS local-port injection scheduler: PE flit FIFO, injection gated on a free network link, starvation flag.
// Optional injection time stamp is compiled in with BLESS_INJ_TIMESTAMP_EN.
module bless_inject_ctrl #(
    parameter int WIDTH        = 64,
    parameter int DEPTH        = 4,
    parameter int TIME_LSB     = 32,
    parameter int TIME_W       = 8,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           pe_flit,
    input  logic                       pe_valid,
    output logic                       pe_ready,
    input  logic [WIDTH-1:0]           dinW,
    input  logic [WIDTH-1:0]           dinE,
    input  logic [WIDTH-1:0]           dinS,
    input  logic [WIDTH-1:0]           dinN,
    output logic [WIDTH-1:0]           inj_flit,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       starved
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [15:0] LIMIT_C = 16'(STARVE_LIMIT);

    if (TIME_LSB + TIME_W > WIDTH) begin : g_bad_time_field
        $error("time field does not fit in the flit");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [15:0]      blk_cnt;
    logic [15:0]      blk_next;
    logic [2:0]       busy;
    logic             all_busy;
    logic             can_inj;
    logic             push_store;
    logic             pop;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] head_out;

    assign fifo_count = count;
    assign head       = mem[rd_ptr];

    always_comb begin
        busy = 3'(dinW != '0) + 3'(dinE != '0) + 3'(dinS != '0) + 3'(dinN != '0);
        all_busy = (busy == 3'd4);
    end

    assign pe_ready   = (count < DEPTH_C) & ~reset;
    assign can_inj    = (count != '0) & ~all_busy & ~reset;
    assign pop        = can_inj;
    // Zero flits complete the handshake but are never stored.
    assign push_store = pe_valid & pe_ready & (pe_flit != '0);
    assign inj_flit   = can_inj ? head_out : '0;

`ifdef BLESS_INJ_TIMESTAMP_EN
    logic [TIME_W-1:0] tcount;

    always_ff @(posedge clk) begin
        if (reset) tcount <= '0;
        else       tcount <= tcount + TIME_W'(1);
    end

    // A stamp that zeroes the whole flit would read as "no flit"; keep it visible.
    always_comb begin
        head_out = head;
        head_out[TIME_LSB +: TIME_W] = tcount;
        if (head_out == '0) head_out[TIME_LSB] = 1'b1;
    end
`else
    assign head_out = head;
`endif

    always_ff @(posedge clk) begin
        if (push_store) mem[wr_ptr] <= pe_flit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_store) wr_ptr <= wr_ptr + AW'(1);
            if (pop)        rd_ptr <= rd_ptr + AW'(1);
            case ({push_store, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        blk_next = blk_cnt;
        if (pop || (count == '0))            blk_next = '0;
        else if (all_busy && (blk_cnt < LIMIT_C)) blk_next = blk_cnt + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            blk_cnt <= '0;
            starved <= 1'b0;
        end else begin
            blk_cnt <= blk_next;
            if (pop)                         starved <= 1'b0;
            else if (blk_next == LIMIT_C)    starved <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bless_inject_ctrl.sv
// Directed bench for bless_inject_ctrl: reset, basic inject, busy links, full FIFO, starvation, zero push, mid-run reset.
// With BLESS_INJ_TIMESTAMP_EN defined the expected flits carry the injection time.
module tb_bless_inject_ctrl;
    logic        clk;
    logic        reset;
    logic [63:0] pe_flit;
    logic        pe_valid;
    logic        pe_ready;
    logic [63:0] dinW, dinE, dinS, dinN;
    logic [63:0] inj_flit;
    logic [2:0]  fifo_count;
    logic        starved;

    int vectors;
    int miscompares;
    logic [7:0] tb_t;

    bless_inject_ctrl #(
        .WIDTH(64), .DEPTH(4), .TIME_LSB(32), .TIME_W(8), .STARVE_LIMIT(16)
    ) dut (
        .clk(clk), .reset(reset),
        .pe_flit(pe_flit), .pe_valid(pe_valid), .pe_ready(pe_ready),
        .dinW(dinW), .dinE(dinE), .dinS(dinS), .dinN(dinN),
        .inj_flit(inj_flit), .fifo_count(fifo_count), .starved(starved)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference time base: cleared by reset, +1 per edge.
    always @(posedge clk) begin
        if (reset) tb_t <= 8'd0;
        else       tb_t <= tb_t + 8'd1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // bit 3 = W, 2 = E, 1 = S, 0 = N
    task automatic set_links(input logic [3:0] b);
        dinW = b[3] ? 64'h8000_0000_0000_0000 : 64'h0;
        dinE = b[2] ? 64'h0000_0000_0000_0001 : 64'h0;
        dinS = b[1] ? 64'h0000_0001_0000_0000 : 64'h0;
        dinN = b[0] ? 64'h0000_0100_0000_0000 : 64'h0;
    endtask

    function automatic logic [63:0] ex(input logic [63:0] f);
        logic [63:0] s;
        s = f;
`ifdef BLESS_INJ_TIMESTAMP_EN
        s[39:32] = tb_t;
        if (s == 64'h0) s[32] = 1'b1;
`endif
        return s;
    endfunction

    task automatic push(input logic [63:0] f);
        pe_valid = 1'b1;
        pe_flit  = f;
        tick();
        pe_valid = 1'b0;
        pe_flit  = 64'h0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset    = 1'b1;
        pe_valid = 1'b0;
        pe_flit  = 64'h0;
        set_links(4'b0000);

        // reset state
        tick();
        tick();
        chk("rst_pe_ready", 64'(pe_ready), 64'd0);
        chk("rst_inj", inj_flit, 64'h0);
        chk("rst_count", 64'(fifo_count), 64'd0);
        chk("rst_starved", 64'(starved), 64'd0);

        // basic push and inject, no bypass
        reset    = 1'b0;
        pe_valid = 1'b1;
        pe_flit  = 64'h0000_0000_0000_00A5;
        #1;
        chk("basic_ready", 64'(pe_ready), 64'd1);
        chk("basic_no_bypass", inj_flit, 64'h0);
        tick();
        pe_valid = 1'b0;
        pe_flit  = 64'h0;
        #1;
        chk("basic_count1", 64'(fifo_count), 64'd1);
        chk("basic_inj", inj_flit, ex(64'h0000_0000_0000_00A5));
        tick();
        chk("basic_count0", 64'(fifo_count), 64'd0);
        chk("basic_idle", inj_flit, 64'h0);

        // all links busy: hold 3 flits, then release in order
        set_links(4'b1111);
        push(64'h1111_0000_0000_0001);
        push(64'h2222_0000_0000_0002);
        push(64'h3333_0000_0000_0003);
        chk("busy_count", 64'(fifo_count), 64'd3);
        for (int i = 0; i < 10; i++) begin
            chk("busy_hold", inj_flit, 64'h0);
            tick();
        end
        set_links(4'b1110);
        #1;
        chk("busy_rel0", inj_flit, ex(64'h1111_0000_0000_0001));
        tick();
        chk("busy_rel1", inj_flit, ex(64'h2222_0000_0000_0002));
        tick();
        chk("busy_rel2", inj_flit, ex(64'h3333_0000_0000_0003));
        tick();
        chk("busy_done_inj", inj_flit, 64'h0);
        chk("busy_done_count", 64'(fifo_count), 64'd0);
        chk("busy_no_starve", 64'(starved), 64'd0);

        // full FIFO; offered flit during the pop cycle is dropped
        set_links(4'b1111);
        push(64'h0000_0000_0000_0A01);
        push(64'h0000_0000_0000_0A02);
        push(64'h0000_0000_0000_0A03);
        push(64'h0000_0000_0000_0A04);
        chk("full_count", 64'(fifo_count), 64'd4);
        chk("full_ready", 64'(pe_ready), 64'd0);
        pe_valid = 1'b1;
        pe_flit  = 64'h0000_0000_0000_0A05;
        set_links(4'b1110);
        #1;
        chk("full_pop_ready", 64'(pe_ready), 64'd0);
        chk("full_pop_inj", inj_flit, ex(64'h0000_0000_0000_0A01));
        tick();
        pe_valid = 1'b0;
        pe_flit  = 64'h0;
        chk("full_count3", 64'(fifo_count), 64'd3);
        chk("full_ready3", 64'(pe_ready), 64'd1);
        chk("full_rest0", inj_flit, ex(64'h0000_0000_0000_0A02));
        tick();
        chk("full_rest1", inj_flit, ex(64'h0000_0000_0000_0A03));
        tick();
        chk("full_rest2", inj_flit, ex(64'h0000_0000_0000_0A04));
        tick();
        chk("full_dropped", inj_flit, 64'h0);
        chk("full_empty", 64'(fifo_count), 64'd0);

        // starvation after exactly 16 blocked edges
        set_links(4'b1111);
        push(64'h5555_0000_0000_0055);
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk($sformatf("starve_edge%0d", k), 64'(starved), (k == 16) ? 64'd1 : 64'd0);
        end
        tick();
        tick();
        chk("starve_hold", 64'(starved), 64'd1);
        set_links(4'b0111);
        #1;
        chk("starve_inj", inj_flit, ex(64'h5555_0000_0000_0055));
        tick();
        chk("starve_clear", 64'(starved), 64'd0);
        chk("starve_empty", 64'(fifo_count), 64'd0);

        // zero push: accepted, never stored
        set_links(4'b0000);
        pe_valid = 1'b1;
        pe_flit  = 64'h0;
        #1;
        chk("zero_ready", 64'(pe_ready), 64'd1);
        tick();
        pe_valid = 1'b0;
        chk("zero_count", 64'(fifo_count), 64'd0);
        chk("zero_inj", inj_flit, 64'h0);

        // reset mid-operation discards queued flits
        set_links(4'b1111);
        push(64'h0000_0000_0000_0B01);
        push(64'h0000_0000_0000_0B02);
        chk("mrst_count2", 64'(fifo_count), 64'd2);
        reset = 1'b1;
        set_links(4'b0000);
        #1;
        chk("mrst_inj_forced", inj_flit, 64'h0);
        chk("mrst_ready_forced", 64'(pe_ready), 64'd0);
        tick();
        chk("mrst_count0", 64'(fifo_count), 64'd0);
        reset = 1'b0;
        #1;
        chk("mrst_inj_after", inj_flit, 64'h0);
        tick();
        tick();
        chk("mrst_inj_later", inj_flit, 64'h0);
        chk("mrst_count_later", 64'(fifo_count), 64'd0);

`ifdef BLESS_INJ_TIMESTAMP_EN
        begin
            logic [7:0]  tgt [3];
            logic [63:0] flt [3];
            logic [63:0] exp_f [3];
            tgt[0] = 8'hFE; flt[0] = 64'h1234_0000_0000_00AB; exp_f[0] = 64'h1234_00FE_0000_00AB;
            tgt[1] = 8'h01; flt[1] = 64'h0000_0000_0000_00CD; exp_f[1] = 64'h0000_0001_0000_00CD;
            tgt[2] = 8'h00; flt[2] = 64'h0000_00FF_0000_0000; exp_f[2] = 64'h0000_0001_0000_0000;
            for (int j = 0; j < 3; j++) begin
                int n;
                set_links(4'b1111);
                push(flt[j]);
                n = 0;
                while ((tb_t != tgt[j]) && (n < 600)) begin
                    tick();
                    n++;
                end
                chk("ts_wait", 64'(tb_t), 64'(tgt[j]));
                set_links(4'b1011);
                #1;
                chk($sformatf("ts_inj%0d", j), inj_flit, exp_f[j]);
                tick();
            end
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
